alu_core: RTL and testbench



---
 rtl/alu_core.sv | 95 +++++++++
 tb/tb_alu_core.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_core.sv
// ---------------------------------------------------------------------------
// alu_core: the execute-stage integer ALU, with registered outputs.
//
// Each cycle one of nine operations on A and B is computed combinationally,
// selected by funct. The result and its zero flag are captured on the next
// rising clock edge. Latency is one cycle and a new operation is accepted
// every cycle.
//
// Ports
//   clock  in   1      system clock, rising-edge active
//   reset  in   1      asynchronous reset, active-high. Forces out=0, flagZ=1.
//   A      in   WIDTH  operand A. This is the value shifted by shift operations.
//   B      in   WIDTH  operand B. B[4:0] is the shift amount for shifts.
//   funct  in   4      operation select. Codes 1001-1111 give a result of 0.
//   out    out  WIDTH  registered result
//   flagZ  out  1      registered zero flag, equal to (out == 0)
// ---------------------------------------------------------------------------
module alu_core #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       funct,
  output logic [WIDTH-1:0] out,
  output logic             flagZ
);

  // The shift amount is the low log2(WIDTH) bits of B. For WIDTH=32 that is
  // B[4:0]. The upper bits of B are ignored, so B=33 shifts by 1.
  localparam int SHW = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_XOR = 4'b0100;
  localparam logic [3:0] OP_NOT = 4'b0101;
  localparam logic [3:0] OP_SLA = 4'b0110;
  localparam logic [3:0] OP_SRA = 4'b0111;
  localparam logic [3:0] OP_SRL = 4'b1000;

  // Returns 1 when every bit of the value is zero.
  function automatic logic is_zero(input logic [WIDTH-1:0] v);
    return (v == {WIDTH{1'b0}});
  endfunction

  logic [SHW-1:0]   shamt_s;
  logic [WIDTH-1:0] out_d;
  logic [WIDTH-1:0] out_q;
  logic             flagz_d;
  logic             flagz_q;

  assign shamt_s = B[SHW-1:0];

  // Next-state result. Reserved codes give zero.
  always_comb begin
    out_d = {WIDTH{1'b0}};
    case (funct)
      OP_ADD:  out_d = A + B;
      OP_SUB:  out_d = A - B;
      OP_AND:  out_d = A & B;
      OP_OR:   out_d = A | B;
      OP_XOR:  out_d = A ^ B;
      OP_NOT:  out_d = ~A;
      OP_SLA:  out_d = A << shamt_s;
      // The signed cast makes >>> replicate A[WIDTH-1] into the vacated bits.
      OP_SRA:  out_d = WIDTH'($signed(A) >>> shamt_s);
      OP_SRL:  out_d = A >> shamt_s;
      default: out_d = {WIDTH{1'b0}};
    endcase
  end

  // The zero flag is taken from the next-state result and registered with
  // it, so flagZ always matches the value on out.
  always_comb begin
    flagz_d = is_zero(out_d);
  end

  // Result and flag registers. Reset clears the result and so sets the flag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_q   <= {WIDTH{1'b0}};
      flagz_q <= 1'b1;
    end else begin
      out_q   <= out_d;
      flagz_q <= flagz_d;
    end
  end

  assign out   = out_q;
  assign flagZ = flagz_q;

endmodule

// File: tb/tb_alu_core.sv
// Self-checking testbench for alu_core. Each expected result is pushed to a
// scoreboard queue when its operands are driven, and is popped and compared
// one rising edge later, once the DUT has captured the result.
module tb_alu_core;

  logic        clock;
  logic        reset;
  logic [31:0] A;
  logic [31:0] B;
  logic [3:0]  funct;
  logic [31:0] out;
  logic        flagZ;

  typedef struct packed {
    logic [31:0] res;
    logic        z;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  alu_core #(.WIDTH(32)) dut (
    .clock (clock),
    .reset (reset),
    .A     (A),
    .B     (B),
    .funct (funct),
    .out   (out),
    .flagZ (flagZ)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model. The arithmetic shift is done bit by bit so that it does
  // not depend on the >>> operator.
  function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic [3:0] f);
    logic [31:0] r;
    int sh;
    sh = int'(b[4:0]);
    case (f)
      4'd0: r = a + b;
      4'd1: r = a + ~b + 32'd1;
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = ~a;
      4'd6: r = a << sh;
      4'd7: begin
        r = a;
        for (int k = 0; k < sh; k++) r = {r[31], r[31:1]};
      end
      4'd8: r = a >> sh;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  task automatic test_reset();
    exp_t e;
    reset = 1'b1; A = 32'd0; B = 32'd0; funct = 4'd0;
    #2;
    checks++;
    if (out !== 32'd0 || flagZ !== 1'b1) begin
      errors++;
      $display("FAIL reset_initial: out=%h flagZ=%b, required out=00000000 flagZ=1", out, flagZ);
    end
    @(negedge clock); reset = 1'b0;
    // Load a nonzero result, then assert reset in the middle of the cycle.
    A = 32'd100; B = 32'd23; funct = 4'b0000;
    sb.push_back('{32'd123, 1'b0});
    @(posedge clock); #1;
    e = sb.pop_front();
    checks++;
    if (out !== e.res || flagZ !== e.z) begin
      errors++;
      $display("FAIL reset_preload: out=%h flagZ=%b, required out=%h flagZ=%b", out, flagZ, e.res, e.z);
    end
    #2; reset = 1'b1; #1;
    checks++;
    if (out !== 32'd0 || flagZ !== 1'b1) begin
      errors++;
      $display("FAIL reset_async: out=%h flagZ=%b, required out=00000000 flagZ=1", out, flagZ);
    end
    @(negedge clock); reset = 1'b0;
    A = 32'd5; B = 32'd7; funct = 4'b0000;
    sb.push_back('{32'd12, 1'b0});
    @(posedge clock); #1;
    e = sb.pop_front();
    checks++;
    if (out !== e.res || flagZ !== e.z) begin
      errors++;
      $display("FAIL reset_release_add: out=%h flagZ=%b, required out=%h flagZ=%b", out, flagZ, e.res, e.z);
    end
    // A reset that arrives at the same time as a capturing edge must win.
    @(negedge clock); A = 32'd9; B = 32'd9; funct = 4'b0000;
    @(posedge clock); reset = 1'b1; #1;
    checks++;
    if (out !== 32'd0 || flagZ !== 1'b1) begin
      errors++;
      $display("FAIL reset_edge_coincident: out=%h flagZ=%b, required out=00000000 flagZ=1", out, flagZ);
    end
    @(negedge clock); reset = 1'b0;
  endtask

  // Applies directed vectors one per cycle. Expected values are literal
  // constants.
  task automatic test_directed();
    logic [31:0] va [13] = '{32'hFFFFFFF6, 32'hFFFFFFFF, 32'hAAAAAAAA, 32'hAAAAAAAA,
                             32'd12, 32'd0, 32'd16, 32'hFFFFFFF4, 32'hAAAAAAAA,
                             32'h80000000, 32'd15, 32'd5, 32'h12345678};
    logic [31:0] vb [13] = '{32'd5, 32'd1, 32'hCCCCCCCC, 32'hCCCCCCCC,
                             32'd7, 32'hDEADBEEF, 32'd2, 32'd2, 32'd4,
                             32'd33, 32'd15, 32'd7, 32'd32};
    logic [3:0]  vf [13] = '{4'b0001, 4'b0000, 4'b0010, 4'b0011,
                             4'b0100, 4'b0101, 4'b0110, 4'b0111, 4'b1000,
                             4'b1000, 4'b0100, 4'b1111, 4'b0110};
    logic [31:0] ve [13] = '{32'hFFFFFFF1, 32'h00000000, 32'h88888888, 32'hEEEEEEEE,
                             32'd11, 32'hFFFFFFFF, 32'd64, 32'hFFFFFFFD, 32'h0AAAAAAA,
                             32'h40000000, 32'd0, 32'd0, 32'h12345678};
    exp_t e;
    for (int i = 0; i < 13; i++) begin
      @(negedge clock);
      A = va[i]; B = vb[i]; funct = vf[i];
      sb.push_back('{ve[i], (ve[i] == 32'd0)});
      @(posedge clock); #1;
      e = sb.pop_front();
      checks++;
      if (out !== e.res || flagZ !== e.z) begin
        errors++;
        $display("FAIL directed[%0d] funct=%b: out=%h flagZ=%b, required out=%h flagZ=%b",
                 i, vf[i], out, flagZ, e.res, e.z);
      end
    end
  endtask

  // Four operations in consecutive cycles. A separate process checks one
  // result per edge, so a gap or a repeated result shows up as a mismatch.
  task automatic test_back_to_back();
    logic [31:0] va [4] = '{32'd1, 32'd50, 32'hF0F0F0F0, 32'h00000003};
    logic [31:0] vb [4] = '{32'd2, 32'd8, 32'h0F0F0F0F, 32'd3};
    logic [3:0]  vf [4] = '{4'b0000, 4'b0001, 4'b0011, 4'b0110};
    logic [31:0] ve [4] = '{32'd3, 32'd42, 32'hFFFFFFFF, 32'd24};
    fork
      begin
        for (int i = 0; i < 4; i++) begin
          @(negedge clock);
          A = va[i]; B = vb[i]; funct = vf[i];
          sb.push_back('{ve[i], (ve[i] == 32'd0)});
        end
      end
      begin
        exp_t e;
        @(negedge clock);
        for (int j = 0; j < 4; j++) begin
          @(posedge clock); #1;
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL b2b[%0d]: scoreboard empty, required 1 pending entry", j);
          end else begin
            e = sb.pop_front();
            if (out !== e.res || flagZ !== e.z) begin
              errors++;
              $display("FAIL b2b[%0d]: out=%h flagZ=%b, required out=%h flagZ=%b",
                       j, out, flagZ, e.res, e.z);
            end
          end
        end
      end
    join
  endtask

  // Random operands and all 16 funct codes, including reserved ones, checked
  // against the reference model.
  task automatic test_random();
    exp_t e;
    logic [31:0] r;
    for (int i = 0; i < 80; i++) begin
      @(negedge clock);
      A = $urandom; B = $urandom; funct = 4'($urandom_range(0, 15));
      if (i % 8 == 0) A = B;
      r = model(A, B, funct);
      sb.push_back('{r, (r == 32'd0)});
      @(posedge clock); #1;
      e = sb.pop_front();
      checks++;
      if (out !== e.res || flagZ !== e.z) begin
        errors++;
        $display("FAIL random[%0d] A=%h B=%h funct=%b: out=%h flagZ=%b, required out=%h flagZ=%b",
                 i, A, B, funct, out, flagZ, e.res, e.z);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
